// File: rtl/fract_muldiv_seq_if.sv
// Handshake and result bundle for the fraction mul/div unit.
// Master drives requests; slave returns status and results.
interface fract_muldiv_seq_if;

  logic        start;
  logic        op_div;
  logic [23:0] fracta;
  logic [23:0] fractb;

  logic        busy;
  logic        done;
  logic [47:0] res;
  logic [23:0] rem;
  logic        sticky;
  logic        div_zero;
  logic        qovf;

  modport master (
    output start,
    output op_div,
    output fracta,
    output fractb,
    input  busy,
    input  done,
    input  res,
    input  rem,
    input  sticky,
    input  div_zero,
    input  qovf
  );

  modport slave (
    input  start,
    input  op_div,
    input  fracta,
    input  fractb,
    output busy,
    output done,
    output res,
    output rem,
    output sticky,
    output div_zero,
    output qovf
  );

endinterface

// File: rtl/fract_muldiv_seq.sv
// Sequential 24x24 fraction multiplier, optional restoring divider.
// Macro FRACT_DIV_EN adds the divide path; otherwise multiply only.
module fract_muldiv_seq (
  input  logic               clk,
  input  logic               rst_n,
  fract_muldiv_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [4:0]  cnt;
  logic        accept;
  logic        last;
  logic        skip;
  logic        busy_c;
  logic        done_c;

  logic [23:0] a_q;
  logic [23:0] p_hi;
  logic [23:0] p_lo;
  logic [24:0] mul_sum;
  logic [47:0] mul_nx;
  logic [47:0] res_q;

  assign accept = bus.start &
                  ((state == IDLE) | (state == DONE));
  assign last   = (state == RUN) & (cnt == 5'd0);

  // One shift-add step: add A on multiplier LSB, shift right.
  assign mul_sum = {1'b0, p_hi} +
                   (p_lo[0] ? {1'b0, a_q} : 25'd0);
  assign mul_nx  = {mul_sum, p_lo[23:1]};

`ifdef FRACT_DIV_EN
  logic        op_q;
  logic [23:0] b_q;
  logic [23:0] r_q;
  logic [26:0] q_q;
  logic [24:0] trial;
  logic        ge;
  logic [23:0] r_nx;
  logic [26:0] q_nx;
  logic [23:0] rem_q;
  logic        dz_in;
  logic        ov_in;
  logic        dz_q;
  logic        ov_q;

  // Quotient must fit in 27 bits, so A < 2B or we saturate.
  assign dz_in = bus.op_div & (bus.fractb == 24'd0);
  assign ov_in = bus.op_div & ~dz_in &
                 ({1'b0, bus.fracta} >= {bus.fractb, 1'b0});
  assign skip  = dz_in | ov_in;

  // First step compares A itself; later steps shift in a zero.
  assign trial = (cnt == 5'd26) ? {1'b0, r_q}
                                : {r_q, 1'b0};
  assign ge    = trial >= {1'b0, b_q};
  assign r_nx  = ge ? 24'(trial - {1'b0, b_q})
                    : trial[23:0];
  assign q_nx  = {q_q[25:0], ge};
`else
  logic        unused_op;

  assign unused_op = bus.op_div;
  assign skip      = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = skip ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt == 5'd0) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_nx = skip ? DONE : RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    unique case (state)
      IDLE:    ;
      RUN:     busy_c = 1'b1;
      DONE:    done_c = 1'b1;
      default: ;
    endcase
  end

  // Iteration counter: loaded on accept, counts down in RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= 5'd0;
    end else if (accept) begin
`ifdef FRACT_DIV_EN
      cnt <= bus.op_div ? 5'd26 : 5'd23;
`else
      cnt <= 5'd23;
`endif
    end else if (state == RUN) begin
      cnt <= cnt - 5'd1;
    end
  end

  // Multiplier working registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q  <= 24'd0;
      p_hi <= 24'd0;
      p_lo <= 24'd0;
    end else if (accept) begin
      a_q  <= bus.fracta;
      p_hi <= 24'd0;
      p_lo <= bus.fractb;
    end else if (state == RUN) begin
      p_hi <= mul_nx[47:24];
      p_lo <= mul_nx[23:0];
    end
  end

`ifdef FRACT_DIV_EN
  // Divider working registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q <= 1'b0;
      b_q  <= 24'd0;
      r_q  <= 24'd0;
      q_q  <= 27'd0;
    end else if (accept) begin
      op_q <= bus.op_div;
      b_q  <= bus.fractb;
      r_q  <= bus.fracta;
      q_q  <= 27'd0;
    end else if ((state == RUN) && op_q) begin
      r_q  <= r_nx;
      q_q  <= q_nx;
    end
  end

  // Result registers, updated only at completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q <= 48'd0;
      rem_q <= 24'd0;
      dz_q  <= 1'b0;
      ov_q  <= 1'b0;
    end else if (accept) begin
      dz_q <= dz_in;
      ov_q <= ov_in;
      if (skip) begin
        res_q <= 48'h7FF_FFFF;
        rem_q <= 24'd0;
      end
    end else if (last) begin
      if (op_q) begin
        res_q <= {21'd0, q_nx};
        rem_q <= r_nx;
      end else begin
        res_q <= mul_nx;
        rem_q <= 24'd0;
      end
    end
  end

  assign bus.rem      = rem_q;
  assign bus.sticky   = |rem_q;
  assign bus.div_zero = dz_q;
  assign bus.qovf     = ov_q;
`else
  // Result register, updated only at completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q <= 48'd0;
    end else if (last) begin
      res_q <= mul_nx;
    end
  end

  assign bus.rem      = 24'd0;
  assign bus.sticky   = 1'b0;
  assign bus.div_zero = 1'b0;
  assign bus.qovf     = 1'b0;
`endif

  assign bus.busy = busy_c;
  assign bus.done = done_c;
  assign bus.res  = res_q;

endmodule

// File: tb/tb_fract_muldiv_seq.sv
// Scoreboard bench for fract_muldiv_seq.
// Define FRACT_DIV_EN to exercise the divide path.
module tb_fract_muldiv_seq;

  logic clk;
  logic rst_n;

  fract_muldiv_seq_if bus ();

  fract_muldiv_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] res;
    logic [23:0] rem;
    logic        st;
    logic        dz;
    logic        ov;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;

  function automatic exp_t model(input logic op,
                                 input logic [23:0] a,
                                 input logic [23:0] b);
    exp_t e;
    logic [49:0] d;
    logic [49:0] q;
    logic [49:0] r;
    e.res = {24'd0, a} * {24'd0, b};
    e.rem = '0;
    e.st  = 1'b0;
    e.dz  = 1'b0;
    e.ov  = 1'b0;
    e.lat = 25;
`ifdef FRACT_DIV_EN
    if (op) begin
      if (b == 24'd0) begin
        e.dz  = 1'b1;
        e.res = 48'h7FF_FFFF;
        e.lat = 1;
      end else if ({1'b0, a} >= {b, 1'b0}) begin
        e.ov  = 1'b1;
        e.res = 48'h7FF_FFFF;
        e.lat = 1;
      end else begin
        d     = {a, 26'd0};
        q     = d / {26'd0, b};
        r     = d % {26'd0, b};
        e.res = {21'd0, q[26:0]};
        e.rem = r[23:0];
        e.st  = |r;
        e.lat = 28;
      end
    end
`else
    e.ov = e.ov & op;
`endif
    return e;
  endfunction

  // Caller is at a negedge; start is accepted at the next posedge.
  task automatic issue(input logic op,
                       input logic [23:0] a,
                       input logic [23:0] b);
    sb.push_back(model(op, a, b));
    bus.start  = 1'b1;
    bus.op_div = op;
    bus.fracta = a;
    bus.fractb = b;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.fracta = 24'($urandom);
    bus.fractb = 24'($urandom);
  endtask

  task automatic collect(input int first,
                         output int lat,
                         output int bz);
    bit hit;
    hit = 1'b0;
    lat = -1;
    bz  = 0;
    for (int c = first; c <= first + 40; c++) begin
      if (!hit) begin
        @(negedge clk);
        if (bus.busy) bz++;
        if (bus.done) begin
          lat = c;
          hit = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.op_div = 1'b0;
    bus.fracta = 24'h123456;
    bus.fractb = 24'h654321;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy got %b want 0", bus.busy);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL rst_done got %b want 0", bus.done);
    end
    checks++;
    if (bus.res !== 48'd0) begin
      errors++;
      $display("FAIL rst_res got %h want 0", bus.res);
    end
    checks++;
    if ({bus.rem, bus.sticky, bus.div_zero, bus.qovf} !== 27'd0) begin
      errors++;
      $display("FAIL rst_flags got %h/%b%b%b want 0",
               bus.rem, bus.sticky, bus.div_zero, bus.qovf);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul;
    exp_t e;
    int lat;
    int bz;
    logic [47:0] held;
    issue(1'b0, 24'h800000, 24'h800000);
    collect(1, lat, bz);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin
      errors++;
      $display("FAIL mul_lat got %0d want %0d", lat, e.lat);
    end
    checks++;
    if (bz !== 24) begin
      errors++;
      $display("FAIL mul_busy got %0d want 24", bz);
    end
    checks++;
    if (bus.res !== e.res) begin
      errors++;
      $display("FAIL mul_res got %h want %h", bus.res, e.res);
    end
    checks++;
    if (bus.rem !== e.rem) begin
      errors++;
      $display("FAIL mul_rem got %h want %h", bus.rem, e.rem);
    end
    held = e.res;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.res !== held) begin
      errors++;
      $display("FAIL mul_hold got %b/%h want 0/%h",
               bus.done, bus.res, held);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int lat;
    int bz;
    issue(1'b0, 24'hFFFFFF, 24'hFFFFFF);
    collect(1, lat, bz);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin
      errors++;
      $display("FAIL b2b1_lat got %0d want %0d", lat, e.lat);
    end
    checks++;
    if (bus.res !== e.res) begin
      errors++;
      $display("FAIL b2b1_res got %h want %h", bus.res, e.res);
    end
    issue(1'b0, 24'h800000, 24'h800000);
    collect(1, lat, bz);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin
      errors++;
      $display("FAIL b2b2_lat got %0d want %0d", lat, e.lat);
    end
    checks++;
    if (bz !== 24) begin
      errors++;
      $display("FAIL b2b2_busy got %0d want 24", bz);
    end
    checks++;
    if (bus.res !== e.res) begin
      errors++;
      $display("FAIL b2b2_res got %h want %h", bus.res, e.res);
    end
    @(negedge clk);
  endtask

  task automatic test_start_in_run;
    exp_t e;
    int lat;
    int bz;
    issue(1'b0, 24'hA5A5A5, 24'h800001);
    repeat (10) @(negedge clk);
    bus.start  = 1'b1;
    bus.op_div = 1'b0;
    bus.fracta = 24'hFFFFFF;
    bus.fractb = 24'hC00000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    collect(11, lat, bz);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin
      errors++;
      $display("FAIL run_start_lat got %0d want %0d", lat, e.lat);
    end
    checks++;
    if (bus.res !== e.res) begin
      errors++;
      $display("FAIL run_start_res got %h want %h", bus.res, e.res);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL run_start_queued got %b%b want 00",
               bus.busy, bus.done);
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    issue(1'b0, 24'hFFFFFF, 24'hFFFFFF);
    void'(sb.pop_front());
    repeat (12) @(negedge clk);
    rst_n      = 1'b0;
    bus.start  = 1'b1;
    bus.fracta = 24'h800000;
    bus.fractb = 24'h800000;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    bus.start = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_activity got %b want 0", seen);
    end
    checks++;
    if (bus.res !== 48'd0) begin
      errors++;
      $display("FAIL rst_mid_res got %h want 0", bus.res);
    end
    checks++;
    if ({bus.rem, bus.sticky, bus.div_zero, bus.qovf} !== 27'd0) begin
      errors++;
      $display("FAIL rst_mid_flags got %h/%b%b%b want 0",
               bus.rem, bus.sticky, bus.div_zero, bus.qovf);
    end
  endtask

`ifdef FRACT_DIV_EN
  task automatic test_div;
    exp_t e;
    int lat;
    int bz;
    logic [23:0] va [4];
    logic [23:0] vb [4];
    va = '{24'hC00000, 24'h800000, 24'h800000, 24'h800000};
    vb = '{24'h800000, 24'hC00000, 24'h000000, 24'h000001};
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, va[i], vb[i]);
      collect(1, lat, bz);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat) begin
        errors++;
        $display("FAIL div%0d_lat got %0d want %0d", i, lat, e.lat);
      end
      checks++;
      if (bus.res !== e.res) begin
        errors++;
        $display("FAIL div%0d_res got %h want %h", i, bus.res, e.res);
      end
      checks++;
      if ({bus.rem, bus.sticky, bus.div_zero, bus.qovf} !==
          {e.rem, e.st, e.dz, e.ov}) begin
        errors++;
        $display("FAIL div%0d_flags got %h/%b%b%b want %h/%b%b%b", i,
                 bus.rem, bus.sticky, bus.div_zero, bus.qovf,
                 e.rem, e.st, e.dz, e.ov);
      end
      @(negedge clk);
    end
  endtask
`else
  task automatic test_nodiv;
    exp_t e;
    int lat;
    int bz;
    issue(1'b1, 24'h800000, 24'h800000);
    collect(1, lat, bz);
    e = sb.pop_front();
    checks++;
    if (lat !== 25) begin
      errors++;
      $display("FAIL nodiv_lat got %0d want 25", lat);
    end
    checks++;
    if (bus.res !== e.res) begin
      errors++;
      $display("FAIL nodiv_res got %h want %h", bus.res, e.res);
    end
    checks++;
    if ({bus.rem, bus.sticky, bus.div_zero, bus.qovf} !== 27'd0) begin
      errors++;
      $display("FAIL nodiv_flags got %h/%b%b%b want 0",
               bus.rem, bus.sticky, bus.div_zero, bus.qovf);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mul();
    test_back_to_back();
    test_start_in_run();
`ifdef FRACT_DIV_EN
    test_div();
`else
    test_nodiv();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fract_muldiv_seq.md
FRACT_MULDIV_SEQ -- requirements
Module: fract_muldiv_seq

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 The block SHALL have `clk`, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL have `rst_n`, input, 1 bit: synchronous active-low reset.
REQ-004 The block SHALL have `start`, input, 1 bit: request; sampled only in IDLE or DONE.
REQ-005 The block SHALL have `op_div`, input, 1 bit: 1 = divide, 0 = multiply; captured with `start`.
REQ-006 The block SHALL have `fracta`, input, 24 bits: operand A with hidden bit at [23], from the pre-normalise stage.
REQ-007 The block SHALL have `fractb`, input, 24 bits: operand B with hidden bit at [23].
REQ-008 The block SHALL have `busy`, output, 1 bit: high in RUN.
REQ-009 The block SHALL have `done`, output, 1 bit: one-cycle pulse; results valid while high and held afterwards.
REQ-010 The block SHALL have `res`, output, 48 bits: product, or zero-extended 27-bit quotient.
REQ-011 The block SHALL have `rem`, output, 24 bits: divide remainder; 0 for multiply.
REQ-012 The block SHALL have `sticky`, output, 1 bit: |rem.
REQ-013 The block SHALL have `div_zero`, output, 1 bit: divide with fractb == 0.
REQ-014 The block SHALL have `qovf`, output, 1 bit: divide with fracta >= 2*fractb and fractb != 0.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE, with a 5-bit iteration counter.
REQ-016 State transitions SHALL be:
- IDLE + start -> RUN;
- RUN -> DONE on the final iteration;
- DONE + start -> RUN;
- DONE without start -> IDLE.
REQ-017 Operands and op_div SHALL be captured on the accepting edge; input changes during RUN SHALL have no effect.
REQ-018 A start while in RUN SHALL be ignored (not queued).
REQ-019 Multiply SHALL be radix-2 shift-add, one bit per cycle, 24 iterations.
- res = fracta*fractb, exact over 48 bits; rem = 0.
- With start accepted in cycle 0, done SHALL be high in cycle 25.
REQ-020 Divide SHALL be restoring division of the 50-bit dividend {fracta, 26'b0} by fractb, 27 iterations.
- res[26:0] = quotient, res[47:27] = 0; rem = remainder (< fractb).
- done SHALL be high in cycle 28.
REQ-021 Divide with fractb == 0 SHALL skip RUN: DONE in cycle 1, res[26:0] = all ones, rem = 0, div_zero = 1.
REQ-022 Divide with fracta >= 2*fractb (fractb != 0) SHALL skip RUN: DONE in cycle 1, res[26:0] = all ones, rem = 0, qovf = 1.
REQ-023 div_zero and qovf SHALL be cleared at every accepted start.
REQ-024 res, rem, sticky, div_zero and qovf SHALL hold their values until the next accepted start updates them at its DONE.
REQ-025 Back-to-back operation (start asserted during the done cycle) SHALL incur zero idle cycles.

Reset
REQ-026 With rst_n low at a rising edge, the block SHALL:
- go to state IDLE with counter = 0;
- drive busy, done, res, rem, sticky, div_zero and qovf to 0.
REQ-027 A reset during RUN SHALL abort the operation with no done pulse.
REQ-028 start in the same cycle as reset SHALL be ignored.

Configuration
REQ-029 Macro FRACT_DIV_EN defined SHALL enable the divide path as specified above.
REQ-030 With FRACT_DIV_EN undefined:
- op_div SHALL be ignored and every operation SHALL be a multiply;
- rem, sticky, div_zero and qovf SHALL be tied 0;
- no divider logic SHALL be synthesised.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- mul 0x800000 x 0x800000, start in cycle 0 -> done in cycle 25, res = 0x400000000000, busy high in cycles 1-24.
- mul 0xFFFFFF x 0xFFFFFF -> res = 0xFFFFFE000001; then start during the done cycle with 0x800000 x 0x800000 -> second done exactly 25 cycles later, res = 0x400000000000.
- div 0xC00000 / 0x800000 -> done in cycle 28, res = 0x0000006000000, rem = 0, sticky = 0; div 0x800000 / 0xC00000 -> res = 0x0000002AAAAAA, rem = 0x800000, sticky = 1.
- div 0x800000 / 0x000000 -> done in cycle 1, div_zero = 1, res = 0x0000007FFFFFF; div 0x800000 / 0x000001 -> done in cycle 1, qovf = 1, res = 0x0000007FFFFFF.
- start during RUN (cycle 10) with different operands -> ignored, original result delivered in cycle 25; rst_n low in cycle 12 of a new multiply -> outputs 0, no done, IDLE.
- FRACT_DIV_EN undefined, op_div = 1, 0x800000 / 0x800000 -> treated as multiply, done in cycle 25, res = 0x400000000000, rem = 0.
